// File: rtl/qupls4_decode_queue_if.sv
// Handshake bundle between the decoder, the decode queue and the rename stage.
interface qupls4_decode_queue_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 512
);
  logic                     flush;
  logic                     in_v;
  logic [DW-1:0]            in_data;
  logic                     dec_en;
  logic                     out_v;
  logic [DW-1:0]            out_data;
  logic                     out_rdy;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;

  modport master (
    output flush, in_v, in_data, out_rdy,
    input  dec_en, out_v, out_data, count, ovf
  );

  modport slave (
    input  flush, in_v, in_data, out_rdy,
    output dec_en, out_v, out_data, count, ovf
  );
endinterface

// File: rtl/qupls4_decode_queue.sv
// Decode queue: first-word fall-through circular buffer between the decoder and rename,
// with a registered decoder enable that leaves SLACK entries for in-flight micro-ops.
module qupls4_decode_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 512,
  parameter int SLACK = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  qupls4_decode_queue_if.slave          bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dec_en_q, ovf_q;
  logic          push, pop, drop;

  always_comb begin
    pop  = (cnt != '0) & bus.out_rdy & ~bus.flush;
    push = bus.in_v & ~bus.flush & ((cnt < CW'(DEPTH)) | pop);
    drop = bus.in_v & ~bus.flush & (cnt == CW'(DEPTH)) & ~pop;
    cnt_nxt = cnt;
    if (bus.flush)
      cnt_nxt = '0;
    else if (push & ~pop)
      cnt_nxt = cnt + 1'b1;
    else if (pop & ~push)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      dec_en_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      dec_en_q <= (cnt_nxt <= CW'(DEPTH - SLACK));
      if (drop)
        ovf_q <= 1'b1;
      if (bus.flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        // Power-of-two depth: pointers wrap naturally at DEPTH-1.
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only observed behind out_v.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wp] <= bus.in_data;
  end

  assign bus.out_v    = (cnt != '0);
  assign bus.out_data = mem[rp];
  assign bus.count    = cnt;
  assign bus.dec_en   = dec_en_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_qupls4_decode_queue.sv
// Self-checking bench for qupls4_decode_queue: a vector table for fill/backpressure/flush,
// hand sequences for reset and a randomised wrap-around stream, all checked by a scoreboard.
module tb_qupls4_decode_queue;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int SLACK = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qupls4_decode_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
  qupls4_decode_queue #(.DEPTH(DEPTH), .DW(DW), .SLACK(SLACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sb[$];
  int            m_count;
  logic          m_ovf;
  logic          m_dec_en;

  typedef struct {
    bit f;
    bit iv;
    bit rdy;
    int exp_count;
    bit exp_dec_en;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then check DUT after the edge.
  task automatic cyc(input logic f, input logic iv, input logic [DW-1:0] d, input logic rdy);
    bit pop, push;
    bus.flush   = f;
    bus.in_v    = iv;
    bus.in_data = d;
    bus.out_rdy = rdy;
    pop  = (m_count != 0) && rdy && !f;
    push = iv && !f && (m_count < DEPTH || pop);
    if (iv && !f && m_count == DEPTH && !pop) m_ovf = 1'b1;
    if (f) begin
      sb.delete();
    end else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(d);
    end
    m_count  = sb.size();
    m_dec_en = (m_count <= DEPTH - SLACK);
    @(posedge clk);
    #1;
    chk("count",  bus.count,  m_count);
    chk("out_v",  bus.out_v,  m_count != 0);
    chk("dec_en", bus.dec_en, m_dec_en);
    chk("ovf",    bus.ovf,    m_ovf);
    if (m_count != 0) chk("head", bus.out_data, sb[0]);
  endtask

  task automatic do_reset(input logic iv);
    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.in_v    = iv;
    bus.in_data = 32'hDEAD;
    bus.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_count  = 0;
    m_ovf    = 1'b0;
    m_dec_en = 1'b1;
    chk("rst_count",  bus.count,  0);
    chk("rst_out_v",  bus.out_v,  0);
    chk("rst_dec_en", bus.dec_en, 1);
    chk("rst_ovf",    bus.ovf,    0);
  endtask

  initial begin
    int sent;
    int budget;
    bit iv;

    for (int i = 0; i < 6; i++) vecs[i] = '{0, 1, 0, i + 1, 1, 0};
    vecs[6]  = '{0, 1, 0, 7, 0, 0};
    vecs[7]  = '{0, 1, 0, 8, 0, 0};
    vecs[8]  = '{0, 1, 0, 8, 0, 1};   // ninth push while full is dropped
    vecs[9]  = '{0, 1, 1, 8, 0, 1};   // push+pop at full
    vecs[10] = '{0, 0, 1, 7, 0, 1};
    vecs[11] = '{0, 0, 1, 6, 1, 1};
    vecs[12] = '{0, 0, 1, 5, 1, 1};
    vecs[13] = '{1, 1, 1, 0, 1, 1};   // flush wins over push/pop, ovf stays sticky
    vecs[14] = '{0, 1, 0, 1, 1, 1};
    vecs[15] = '{0, 1, 0, 2, 1, 1};
    vecs[16] = '{0, 1, 0, 3, 1, 1};

    do_reset(1'b0);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].f, vecs[i].iv, 32'hA000 + i, vecs[i].rdy);
      chk($sformatf("vec%0d_count", i),  bus.count,  vecs[i].exp_count);
      chk($sformatf("vec%0d_dec_en", i), bus.dec_en, vecs[i].exp_dec_en);
      chk($sformatf("vec%0d_ovf", i),    bus.ovf,    vecs[i].exp_ovf);
    end

    // Reset with count=3 and ovf set, in_v held high to show reset overrides push.
    do_reset(1'b1);

    // First entry after reset is the first accepted in_v.
    cyc(1'b0, 1'b1, 32'hB001, 1'b0);
    chk("post_rst_head", bus.out_data, 32'hB001);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Wrap-around stream honouring dec_en with random backpressure.
    sent   = 0;
    budget = 0;
    while ((sent < 20 || m_count != 0) && budget < 300) begin
      iv = (sent < 20) && bus.dec_en;
      cyc(1'b0, iv, 32'hC000 + sent, 1'($urandom_range(0, 1)));
      if (iv) sent++;
      budget++;
    end
    chk("stream_sent",    sent,      20);
    chk("stream_drained", bus.count, 0);
    chk("stream_ovf",     bus.ovf,   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
